data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Responder end of the core's data-memory port: takes the address, write data and read/write strobes the core drives, and returns read bytes plus a ready handshake.
- Direct-mapped, one-word-line, write-through, no-write-allocate cache in front of an internal word-addressed backing memory with fixed multi-cycle access latency.
- Sits between the core's data port and the backing store. The core's data port gains mem_read_en and honours mem_ready (stalls while low).

Parameters:
- INDEX_BITS, 3, log2 of line count (default 8 lines).
- MEM_ADDR_BITS, 10, log2 of backing-memory words (default 1024 words).
- MISS_LATENCY, 4, backing-memory access cycles; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset; asynchronous, active-low.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_data_in  in  8x4 (array [0:3])  write data; [0] is the MSB byte.
- mem_write_en  in  1  write request.
- mem_read_en  in  1  read request.
- mem_data_out  out  8x4 (array [0:3])  read data; [0] is the MSB byte.
- mem_ready  out  1  request complete this cycle.
- hit_count  out  16  saturating read-hit counter.
- miss_count  out  16  saturating read-miss counter.

Behaviour:
- Word address: mem_addr[MEM_ADDR_BITS+1:2]; higher bits alias.
- Index: mem_addr[INDEX_BITS+1:2]. Tag: mem_addr[MEM_ADDR_BITS+1:INDEX_BITS+2].
- Reset (async, rst_b=0):
  - FSM to IDLE; all valid bits cleared; counters cleared.
  - mem_ready=0 and mem_data_out=0 while in reset.
  - Backing memory and line data are not reset.
  - Reset during MISS/WRITE abandons the operation: no line fill and no backing write.
- FSM states: IDLE, MISS, WRITE. A 4-bit down-counter cnt is used in MISS/WRITE.
- IDLE:
  - Write requested (wins if both strobes high): latch address and data, cnt=MISS_LATENCY-1, go to WRITE. mem_ready=0.
  - Read requested, valid and tag match (hit): mem_ready=1 combinationally in the same cycle; mem_data_out = line word; hit_count++. Zero-latency hit.
  - Read requested, miss: latch address, cnt=MISS_LATENCY-1, go to MISS. mem_ready=0. miss_count++ at this edge.
  - No request: mem_ready=0; mem_data_out holds its last driven value.
- MISS:
  - While cnt!=0: mem_ready=0; cnt decrements each cycle.
  - When cnt==0: mem_ready=1; mem_data_out = backing word at the latched address.
  - At that edge: line filled (data, tag, valid=1), return to IDLE.
  - Read-miss completion therefore arrives MISS_LATENCY cycles after the request cycle.
- WRITE:
  - Same counting as MISS.
  - When cnt==0: mem_ready=1. At that edge the backing word is written with the latched data.
  - If the line is valid with a matching tag, line data is updated in the same edge; otherwise the line is untouched.
  - Return to IDLE.
- Requester rule: after seeing mem_ready=1, the requester changes or drops the request next cycle. A request still held in IDLE is treated as new (a held write repeats).
- Inputs changing during MISS/WRITE have no effect; latched values are used.
- MISS_LATENCY=1: MISS/WRITE last exactly one cycle with ready=1.
- Counters saturate at 16'hFFFF; no wrap.
- Writes do not count as hits or misses.

Test Plan:
- Reset, write 0xDEADBEEF to 0x40 (bytes [0]=DE … [3]=EF) -> mem_ready low 3 cycles, high on the 4th; no counter change.
- Read 0x40 after that write -> miss (no-allocate); ready on the 4th cycle with bytes DE,AD,BE,EF; miss_count=1. Immediate re-read -> ready in the same cycle, same data, hit_count=1.
- Read 0x40, then read 0x60 (same index, different tag), then 0x40 again -> miss, miss, miss; miss_count=3, hit_count=0.
- Write 0x11223344 to cached 0x40 -> completes after 4 cycles; next read of 0x40 hits with 11,22,33,44.
- Assert rst_b=0 two cycles into a write of 0xCAFEF00D to 0x80 -> ready never asserts; after reset, reading 0x80 returns the old backing value and all valids are cleared (0x40 misses).
- Assert read and write together to 0x100 -> treated as a write (WRITE state, no counter change). Separately, force hit_count to 0xFFFF -> further hits leave it at 0xFFFF.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache
// with an internal fixed-latency word-addressed backing memory.
module data_cache #(
  parameter int INDEX_BITS    = 3,
  parameter int MEM_ADDR_BITS = 10,
  parameter int MISS_LATENCY  = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in [0:3],
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << MEM_ADDR_BITS;
  localparam int TAG_BITS = MEM_ADDR_BITS - INDEX_BITS;
  localparam logic [3:0] CNT_INIT = 4'(MISS_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [MEM_ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              dout_q, dout_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [15:0]              hit_count_q, hit_count_d;
  logic [15:0]              miss_count_q, miss_count_d;

  // Line storage and backing memory carry no reset; only valid bits do.
  logic [31:0]         line_data_q [LINES];
  logic [TAG_BITS-1:0] line_tag_q  [LINES];
  logic [31:0]         mem_q       [WORDS];

  logic [MEM_ADDR_BITS-1:0] req_word;
  logic [INDEX_BITS-1:0]    req_idx, lat_idx;
  logic [TAG_BITS-1:0]      req_tag, lat_tag;
  logic [31:0]              wdata_in, dout;
  logic                     hit, ready, fill_en, line_wr_en, mem_wr_en;
  logic                     unused_addr;

  assign req_word    = mem_addr[MEM_ADDR_BITS+1:2];
  assign req_idx     = req_word[INDEX_BITS-1:0];
  assign req_tag     = req_word[MEM_ADDR_BITS-1:INDEX_BITS];
  assign lat_idx     = waddr_q[INDEX_BITS-1:0];
  assign lat_tag     = waddr_q[MEM_ADDR_BITS-1:INDEX_BITS];
  assign wdata_in    = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
  assign hit         = valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
  assign unused_addr = ^{mem_addr[31:MEM_ADDR_BITS+2], mem_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    ready        = 1'b0;
    dout         = dout_q;
    fill_en      = 1'b0;
    line_wr_en   = 1'b0;
    mem_wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write_en) begin
          waddr_d = req_word;
          wdata_d = wdata_in;
          cnt_d   = CNT_INIT;
          state_d = WRITE;
        end else if (mem_read_en) begin
          if (hit) begin
            ready = 1'b1;
            dout  = line_data_q[req_idx];
            if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
          end else begin
            waddr_d = req_word;
            cnt_d   = CNT_INIT;
            state_d = MISS;
            if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
          end
        end
      end
      MISS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready            = 1'b1;
          dout             = mem_q[waddr_q];
          fill_en          = 1'b1;
          valid_d[lat_idx] = 1'b1;
          state_d          = IDLE;
        end
      end
      WRITE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready      = 1'b1;
          mem_wr_en  = 1'b1;
          // Write-through: refresh the line only if it already holds this word.
          line_wr_en = valid_q[lat_idx] && (line_tag_q[lat_idx] == lat_tag);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dout_d = dout;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      dout_q       <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Enables derive from state_q, which reset forces to IDLE, so an abandoned op writes nothing.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[waddr_q] <= wdata_q;
    if (fill_en) begin
      line_data_q[lat_idx] <= mem_q[waddr_q];
      line_tag_q[lat_idx]  <= lat_tag;
    end else if (line_wr_en) begin
      line_data_q[lat_idx] <= wdata_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[i] = dout[8*(3-i) +: 8];
  end

  assign mem_ready  = ready;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: vector table through a scoreboard queue, plus reset-abort,
// saturation and single-cycle-latency sequences.
module tb_data_cache;
  localparam int LAT = 5;  // request cycle + MISS_LATENCY(4)

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] addr;
  logic [7:0]  din [0:3];
  logic        we, re;
  logic [7:0]  dout [0:3];
  logic        ready;
  logic [15:0] hits, misses;

  logic [31:0] l_addr;
  logic [7:0]  l_din [0:3];
  logic        l_we, l_re;
  logic [7:0]  l_dout [0:3];
  logic        l_ready;
  logic [15:0] l_hits, l_misses;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(addr), .mem_data_in(din),
    .mem_write_en(we), .mem_read_en(re), .mem_data_out(dout),
    .mem_ready(ready), .hit_count(hits), .miss_count(misses)
  );

  data_cache #(.MISS_LATENCY(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .mem_addr(l_addr), .mem_data_in(l_din),
    .mem_write_en(l_we), .mem_read_en(l_re), .mem_data_out(l_dout),
    .mem_ready(l_ready), .hit_count(l_hits), .miss_count(l_misses)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] data;
    bit          chkd;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
    bit          chkd;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b [0:3]);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic run_op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input int elat, input logic [31:0] edata, input bit chkd, input string nm);
    exp_t e;
    int n;
    @(negedge clk);
    we = w; re = r; addr = a;
    for (int i = 0; i < 4; i++) din[i] = wd[8*(3-i) +: 8];
    sbq.push_back('{elat, edata, chkd});
    n = 1;
    #1;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
      #1;
    end
    e = sbq.pop_front();
    if (!ready) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for ready after %0d cycles", nm, n);
    end else begin
      chk({nm, " latency"}, n, e.lat);
      if (e.chkd) chk({nm, " data"}, pack(dout), e.data);
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h40,   32'hDEADBEEF, LAT, 32'h0,        1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h40,   32'h0,        LAT, 32'hDEADBEEF, 1'b1, 16'd0, 16'd1};
    tbl[2]  = '{1'b0, 1'b1, 32'h40,   32'h0,        1,   32'hDEADBEEF, 1'b1, 16'd1, 16'd1};
    tbl[3]  = '{1'b1, 1'b0, 32'h60,   32'hA5A55A5A, LAT, 32'h0,        1'b0, 16'd1, 16'd1};
    tbl[4]  = '{1'b0, 1'b1, 32'h60,   32'h0,        LAT, 32'hA5A55A5A, 1'b1, 16'd1, 16'd2};
    tbl[5]  = '{1'b0, 1'b1, 32'h40,   32'h0,        LAT, 32'hDEADBEEF, 1'b1, 16'd1, 16'd3};
    tbl[6]  = '{1'b0, 1'b1, 32'h60,   32'h0,        LAT, 32'hA5A55A5A, 1'b1, 16'd1, 16'd4};
    tbl[7]  = '{1'b0, 1'b1, 32'h60,   32'h0,        1,   32'hA5A55A5A, 1'b1, 16'd2, 16'd4};
    tbl[8]  = '{1'b1, 1'b0, 32'h60,   32'h11223344, LAT, 32'h0,        1'b0, 16'd2, 16'd4};
    tbl[9]  = '{1'b0, 1'b1, 32'h60,   32'h0,        1,   32'h11223344, 1'b1, 16'd3, 16'd4};
    tbl[10] = '{1'b1, 1'b0, 32'h40,   32'hCAFE0001, LAT, 32'h0,        1'b0, 16'd3, 16'd4};
    tbl[11] = '{1'b0, 1'b1, 32'h40,   32'h0,        LAT, 32'hCAFE0001, 1'b1, 16'd3, 16'd5};
    tbl[12] = '{1'b1, 1'b1, 32'h100,  32'h01020304, LAT, 32'h0,        1'b0, 16'd3, 16'd5};
    tbl[13] = '{1'b0, 1'b1, 32'h100,  32'h0,        LAT, 32'h01020304, 1'b1, 16'd3, 16'd6};
    tbl[14] = '{1'b0, 1'b1, 32'h100,  32'h0,        1,   32'h01020304, 1'b1, 16'd4, 16'd6};
    tbl[15] = '{1'b0, 1'b1, 32'h1103, 32'h0,        1,   32'h01020304, 1'b1, 16'd5, 16'd6};
    tbl[16] = '{1'b1, 1'b0, 32'h80,   32'h13579BDF, LAT, 32'h0,        1'b0, 16'd5, 16'd6};

    we = 0; re = 0; addr = 0; l_we = 0; l_re = 0; l_addr = 0;
    for (int i = 0; i < 4; i++) begin din[i] = 8'h0; l_din[i] = 8'h0; end
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", {31'b0, ready}, 32'h0);
    chk("reset dout", pack(dout), 32'h0);
    chk("reset hits", {16'h0, hits}, 32'h0);
    chk("reset misses", {16'h0, misses}, 32'h0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 17; k++) begin
      run_op(tbl[k].we, tbl[k].re, tbl[k].addr, tbl[k].wd, tbl[k].lat, tbl[k].data,
             tbl[k].chkd, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d hits", k), {16'h0, hits}, {16'h0, tbl[k].hits});
      chk($sformatf("vec%0d misses", k), {16'h0, misses}, {16'h0, tbl[k].misses});
    end

    // Reset two cycles into a write: the write must be abandoned.
    @(negedge clk);
    we = 1'b1; addr = 32'h80;
    for (int i = 0; i < 4; i++) din[i] = 8'(32'hCAFEF00D >> (8*(3-i)));
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("abort ready c%0d", c), {31'b0, ready}, 32'h0);
      @(negedge clk);
    end
    #2;
    rst_b = 1'b0;
    #1;
    chk("abort ready in reset", {31'b0, ready}, 32'h0);
    chk("abort dout in reset", pack(dout), 32'h0);
    chk("abort hits cleared", {16'h0, hits}, 32'h0);
    chk("abort misses cleared", {16'h0, misses}, 32'h0);
    we = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    run_op(1'b0, 1'b1, 32'h80, 32'h0, LAT, 32'h13579BDF, 1'b1, "post-reset 0x80");
    run_op(1'b0, 1'b1, 32'h60, 32'h0, LAT, 32'h11223344, 1'b1, "post-reset 0x60 miss");
    chk("post-reset misses", {16'h0, misses}, 32'd2);
    chk("post-reset hits", {16'h0, hits}, 32'd0);

    // Hit counter saturation.
    force dut.hit_count_q = 16'hFFFE;
    #1;
    release dut.hit_count_q;
    run_op(1'b0, 1'b1, 32'h60, 32'h0, 1, 32'h11223344, 1'b1, "sat hit1");
    chk("sat hits 1", {16'h0, hits}, 32'h0000FFFF);
    run_op(1'b0, 1'b1, 32'h60, 32'h0, 1, 32'h11223344, 1'b1, "sat hit2");
    chk("sat hits 2", {16'h0, hits}, 32'h0000FFFF);
    chk("sat misses", {16'h0, misses}, 32'd2);

    // MISS_LATENCY=1: write and miss each complete one cycle after the request.
    @(negedge clk);
    l_we = 1'b1; l_addr = 32'h20;
    for (int i = 0; i < 4; i++) l_din[i] = 8'(32'h89ABCDEF >> (8*(3-i)));
    #1 chk("lat1 write req cycle", {31'b0, l_ready}, 32'h0);
    @(negedge clk);
    #1 chk("lat1 write done", {31'b0, l_ready}, 32'h1);
    @(posedge clk); #1 l_we = 1'b0;
    @(negedge clk);
    l_re = 1'b1;
    #1 chk("lat1 read req cycle", {31'b0, l_ready}, 32'h0);
    @(negedge clk);
    #1 chk("lat1 read done", {31'b0, l_ready}, 32'h1);
    chk("lat1 read data", pack(l_dout), 32'h89ABCDEF);
    @(posedge clk); #1 l_re = 1'b0;
    @(negedge clk);
    chk("lat1 misses", {16'h0, l_misses}, 32'd1);
    l_re = 1'b1;
    #1 chk("lat1 hit ready", {31'b0, l_ready}, 32'h1);
    chk("lat1 hit data", pack(l_dout), 32'h89ABCDEF);
    @(posedge clk); #1 l_re = 1'b0;
    @(negedge clk);
    chk("lat1 hits", {16'h0, l_hits}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
